// File: rtl/im_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package im_loader_pkg;

  localparam int INSTR_W_DEF  = 15;
  localparam int ADDR_W_DEF   = 8;
  localparam int IM_DEPTH_DEF = 256;

  localparam logic [7:0] CHK_SEED = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte stream into the loader plus the loader's IM write port.
interface im_loader_if import im_loader_pkg::*; #(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) ();

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/im_loader_chk.sv
// Running XOR of accepted frame bytes; zero reports whether the presented
// byte would bring the accumulator to zero (i.e. it is a matching checksum).
module im_loader_chk import im_loader_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic       zero
);

  logic [7:0] acc_r;

  // Accumulator: clear has priority over a simultaneous byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= CHK_SEED;
    end else if (clr) begin
      acc_r <= CHK_SEED;
    end else if (en) begin
      acc_r <= chk_fold(acc_r, data);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign zero = (chk_fold(acc_r, data) == 8'h00);

endmodule

// File: rtl/im_loader.sv
// Frame parser, word assembler and IM write port; holds the CPU stopped
// until a complete frame with a good checksum has been written.
module im_loader import im_loader_pkg::*; #(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int IM_DEPTH = IM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  im_loader_if.master       bus,
  output logic              cpu_run,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // HI bits that do not land in the instruction word and must be zero.
  localparam logic [7:0] HI_MASK = 8'(16'h00FF << (INSTR_W - 8));

  state_t             state_r;
  state_t             state_nxt;
  logic [ADDR_W:0]    n_r;
  logic [ADDR_W:0]    cnt_r;
  logic [7:0]         lo_r;
  logic               im_we_r;
  logic [ADDR_W-1:0]  im_addr_r;
  logic [INSTR_W-1:0] im_wdata_r;
  logic               done_r;
  logic               error_r;
  logic               run_r;

  logic               xfer;
  logic               len_bad;
  logic               hi_bad;
  logic               last_word;
  logic               chk_en;
  logic               chk_ok;
  logic [INSTR_W-1:0] word;

  assign bus.in_ready = (state_r inside {LEN, LO, HI, CHK}) && !start;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign len_bad      = (bus.in_data == 8'h00) || (32'(bus.in_data) > 32'(IM_DEPTH));
  assign hi_bad       = (bus.in_data & HI_MASK) != 8'h00;
  assign last_word    = (cnt_r + (ADDR_W+1)'(1)) >= n_r;
  assign word         = INSTR_W'({bus.in_data, lo_r});
  assign chk_en       = xfer && (state_r inside {LEN, LO, HI});

  im_loader_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (chk_en),
    .data  (bus.in_data),
    .zero  (chk_ok)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode; start overrides every state and any pending byte.
  always_comb begin
    state_nxt = state_r;
    if (start) begin
      state_nxt = LEN;
    end else begin
      case (state_r)
        IDLE: state_nxt = IDLE;
        LEN: begin
          if (xfer && len_bad) begin
            state_nxt = ERR;
          end else if (xfer) begin
            state_nxt = LO;
          end else begin
            state_nxt = LEN;
          end
        end
        LO: begin
          if (xfer) begin
            state_nxt = HI;
          end else begin
            state_nxt = LO;
          end
        end
        HI: begin
          if (xfer && hi_bad) begin
            state_nxt = ERR;
          end else if (xfer && last_word) begin
            state_nxt = CHK;
          end else if (xfer) begin
            state_nxt = LO;
          end else begin
            state_nxt = HI;
          end
        end
        CHK: begin
          if (xfer && chk_ok) begin
            state_nxt = DONE;
          end else if (xfer) begin
            state_nxt = ERR;
          end else begin
            state_nxt = CHK;
          end
        end
        DONE:    state_nxt = DONE;
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Length/low-byte latches, word counter and the registered IM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r        <= '0;
      cnt_r      <= '0;
      lo_r       <= 8'h00;
      im_we_r    <= 1'b0;
      im_addr_r  <= '0;
      im_wdata_r <= '0;
    end else if (start) begin
      n_r        <= '0;
      cnt_r      <= '0;
      lo_r       <= 8'h00;
      im_we_r    <= 1'b0;
    end else begin
      im_we_r <= 1'b0;
      if (xfer && (state_r == LEN)) begin
        n_r <= (ADDR_W+1)'(bus.in_data);
      end
      if (xfer && (state_r == LO)) begin
        lo_r <= bus.in_data;
      end
      if (xfer && (state_r == HI) && !hi_bad) begin
        im_we_r    <= 1'b1;
        im_addr_r  <= cnt_r[ADDR_W-1:0];
        im_wdata_r <= word;
        cnt_r      <= cnt_r + (ADDR_W+1)'(1);
      end
    end
  end

  // Status flags follow the state being entered, so they stay sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      run_r   <= 1'b0;
    end else begin
      done_r  <= (state_nxt == DONE);
      error_r <= (state_nxt == ERR);
      run_r   <= (state_nxt == DONE);
    end
  end

  assign bus.im_we    = im_we_r;
  assign bus.im_addr  = im_addr_r;
  assign bus.im_wdata = im_wdata_r;
  assign done         = done_r;
  assign error        = error_r;
  assign cpu_run      = run_r;
  assign words_loaded = cnt_r;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader against a frame-level reference model.
module tb_im_loader;

  localparam int IW    = 15;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  typedef struct {
    int idx;
    int addr;
    int data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_run;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  im_loader_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();

  im_loader #(.INSTR_W(IW), .ADDR_W(AW), .IM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] fr[$];
  wr_t        exp_q[$];
  int         pend = -1;
  logic       exp_done;
  logic       exp_err;
  int         exp_cons;
  int         exp_words;
  int         last_addr = -1;
  int         last_data = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: which byte index causes which write, and the outcome.
  task automatic ref_model();
    int         n;
    logic [7:0] acc;
    logic [7:0] lo;
    logic [7:0] hi;
    wr_t        w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n   = int'(fr[0]);
    acc = fr[0];
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1; exp_cons = 1; exp_words = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      lo  = fr[1 + 2*i];
      hi  = fr[2 + 2*i];
      acc = acc ^ lo ^ hi;
      if (hi[7]) begin
        exp_err = 1'b1; exp_cons = 3 + 2*i; exp_words = i;
        return;
      end
      w.idx  = 2 + 2*i;
      w.addr = i;
      w.data = int'(hi[6:0]) * 256 + int'(lo);
      exp_q.push_back(w);
    end
    exp_cons  = 2*n + 2;
    exp_words = n;
    if ((acc ^ fr[1 + 2*n]) == 8'h00) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic gen_frame(input int n, input int mode);
    logic [7:0] acc;
    logic [7:0] lo;
    logic [7:0] hi;
    int         bad;
    fr.delete();
    fr.push_back(8'(n));
    acc = 8'(n);
    bad = (n > 0) ? $urandom_range(0, n - 1) : 0;
    for (int i = 0; i < n; i++) begin
      lo = 8'($urandom);
      hi = {1'b0, 7'($urandom)};
      if (mode == 2 && i == bad) hi[7] = 1'b1;
      fr.push_back(lo);
      fr.push_back(hi);
      acc = acc ^ lo ^ hi;
    end
    if (mode == 1) acc = acc ^ 8'($urandom_range(1, 255));
    fr.push_back(acc);
  endtask

  // Checks the write port for the byte accepted on the previous edge.
  task automatic check_we();
    if (exp_q.size() > 0 && exp_q[0].idx == pend) begin
      check_eq("im_we", 32'(bus.im_we), 32'd1);
      check_eq("im_addr", 32'(bus.im_addr), 32'(exp_q[0].addr));
      check_eq("im_wdata", 32'(bus.im_wdata), 32'(exp_q[0].data));
      check_eq("words_at_write", 32'(words_loaded), 32'(exp_q[0].addr + 1));
      last_addr = int'(bus.im_addr);
      last_data = int'(bus.im_wdata);
      void'(exp_q.pop_front());
    end else begin
      check_eq("im_we_idle", 32'(bus.im_we), 32'd0);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input int idx, output logic took);
    @(negedge clk);
    check_we();
    start = 1'b0;
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    took = v && bus.in_ready;
    pend = took ? idx : -1;
  endtask

  task automatic pulse_start(input logic v, input logic [7:0] d);
    @(negedge clk);
    check_we();
    start = 1'b1;
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    check_eq("ready_during_start", 32'(bus.in_ready), 32'd0);
    pend = -1;
  endtask

  // gap: 0 full rate, 1 bubble before every byte, 2 random bubbles.
  task automatic run_frame(input int gap, input logic do_start);
    logic took;
    int   tries;
    if (do_start) pulse_start(1'b0, 8'h00);
    ref_model();
    for (int k = 0; k < exp_cons; k++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) step(1'b0, 8'($urandom), -1, took);
      took  = 1'b0;
      tries = 0;
      while (!took && tries < 4) begin
        step(1'b1, fr[k], k, took);
        tries++;
      end
      check_eq("byte_accept", 32'(took), 32'd1);
      if (k == 0) begin
        check_eq("words_clr", 32'(words_loaded), 32'd0);
        check_eq("done_clr", 32'(done), 32'd0);
        check_eq("error_clr", 32'(error), 32'd0);
      end
    end
    @(negedge clk);
    check_we();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    #1;
    pend = -1;
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("error", 32'(error), 32'(exp_err));
    check_eq("cpu_run", 32'(cpu_run), 32'(exp_done));
    check_eq("words_loaded", 32'(words_loaded), 32'(exp_words));
    check_eq("ready_after", 32'(bus.in_ready), 32'd0);
    check_eq("writes_missing", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic took;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #23;
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_run", 32'(cpu_run), 32'd0);
    check_eq("rst_we", 32'(bus.im_we), 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h02, -1, took);
      check_eq("idle_ready", 32'(bus.in_ready), 32'd0);
    end

    // Nominal frame at full rate.
    fr = '{8'h02, 8'h63, 8'h05, 8'h10, 8'h00, 8'h74};
    run_frame(0, 1'b1);
    check_eq("nom_last_addr", 32'(last_addr), 32'h01);
    check_eq("nom_last_data", 32'(last_data), 32'h0010);

    // Same frame, bad checksum.
    fr = '{8'h02, 8'h63, 8'h05, 8'h10, 8'h00, 8'h75};
    run_frame(0, 1'b1);

    // Illegal HI byte; nothing written.
    last_addr = -1;
    fr = '{8'h01, 8'h12, 8'h80};
    run_frame(0, 1'b1);
    check_eq("badhi_no_write", 32'(last_addr), 32'hFFFF_FFFF);

    // Zero length.
    fr = '{8'h00};
    run_frame(0, 1'b1);

    // Longest frame the LEN byte can express.
    gen_frame(255, 0);
    run_frame(0, 1'b1);
    check_eq("max_last_addr", 32'(last_addr), 32'hFE);

    // in_valid toggling every other cycle.
    fr = '{8'h02, 8'h63, 8'h05, 8'h10, 8'h00, 8'h74};
    run_frame(1, 1'b1);

    // Abort while in HI: the byte presented with start is dropped.
    gen_frame(3, 0);
    pulse_start(1'b0, 8'h00);
    ref_model();
    step(1'b1, fr[0], 0, took);
    check_eq("abort_len_accept", 32'(took), 32'd1);
    step(1'b1, fr[1], 1, took);
    check_eq("abort_lo_accept", 32'(took), 32'd1);
    @(negedge clk);
    check_we();
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = fr[2];
    #1;
    check_eq("abort_ready", 32'(bus.in_ready), 32'd0);
    pend = -1;
    gen_frame(2, 0);
    run_frame(0, 1'b0);

    // Randomized frames of mixed legality and pacing.
    for (int t = 0; t < 24; t++) begin
      gen_frame($urandom_range(0, 8), $urandom_range(0, 2));
      run_frame(2, 1'b1);
    end

    // Asynchronous reset in the middle of a frame.
    gen_frame(4, 0);
    pulse_start(1'b0, 8'h00);
    ref_model();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, fr[k], k, took);
    end
    check_eq("pre_reset_words", 32'(words_loaded), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_error", 32'(error), 32'd0);
    check_eq("arst_run", 32'(cpu_run), 32'd0);
    check_eq("arst_we", 32'(bus.im_we), 32'd0);
    check_eq("arst_addr", 32'(bus.im_addr), 32'd0);
    check_eq("arst_wdata", 32'(bus.im_wdata), 32'd0);
    check_eq("arst_words", 32'(words_loaded), 32'd0);
    check_eq("arst_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    pend = -1;
    #13;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), -1, took);
      check_eq("post_reset_ready", 32'(bus.in_ready), 32'd0);
    end
    gen_frame(5, 0);
    run_frame(0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
